// File: rtl/loop_checker_pkg.sv
// ---------------------------------------------------------------------------
// loop_checker_pkg
// Shared constants for the loop result checker:
//   - default widths (data word, bank address, statistics counters)
//   - binary FSM state encoding
//   - popcount result width helper
// ---------------------------------------------------------------------------
package loop_checker_pkg;

  localparam int DEF_DATA_WIDTH = 56;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_CNT_WIDTH  = 16;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPARE = 2'd1;
  localparam logic [1:0] S_ACCUM   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  // Bits needed to hold a count of 0..data_width set bits.
  function automatic int pcnt_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

  localparam int DEF_PCNT_WIDTH = pcnt_width(DEF_DATA_WIDTH);

endpackage

// File: rtl/loop_checker_popcount.sv
// ---------------------------------------------------------------------------
// loop_checker_popcount
// Purely combinational population count of a DATA_WIDTH-bit word.
// Ports:
//   data   in   DATA_WIDTH   word to count
//   count  out  PCNT_WIDTH   number of set bits in data
// ---------------------------------------------------------------------------
module loop_checker_popcount
  import loop_checker_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PCNT_WIDTH = pcnt_width(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic [PCNT_WIDTH-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      count = count + PCNT_WIDTH'(data[i]);
    end
  end

endmodule

// File: rtl/loop_result_checker.sv
// ---------------------------------------------------------------------------
// loop_result_checker
// Captures received loop words into a ping-pong RX bank and, after each
// loop end, compares them word by word against a host-loaded expected
// pattern bank, accumulating saturating word/bit error and loop counters.
//
// Optional feature macro: LOOP_RESULT_CHECKER_ERR_LOG_EN
//   defined   -> first error (index + received word) since reset/clear is
//                latched on o_first_err_addr / o_first_err_data
//   undefined -> both ports tied to 0, no storage
//
// Ports:
//   i_clk, i_arst          clock, asynchronous active-high reset
//   i_loop_start           loop start pulse; latches i_pattern_num
//   i_loop_done            loop end pulse; launches a check when idle
//   i_pattern_num          last valid word index of the loop
//   i_bank_l/addr/wr       received word write port (capture bank)
//   i_pat_wr/addr/data     expected pattern write port (host)
//   i_clear                synchronous clear of statistics and sticky flags
//   o_busy                 check in progress
//   o_check_done           one-cycle pulse at the end of a check
//   o_pass                 last checked loop had no word error
//   o_word_err_cnt         saturating erroneous word count
//   o_bit_err_cnt          saturating erroneous bit count
//   o_loop_cnt             saturating checked loop count
//   o_overrun              sticky: loop end seen while checking
//   o_first_err_addr/data  first error since reset/clear (optional)
// ---------------------------------------------------------------------------
module loop_result_checker
  import loop_checker_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_loop_start,
  input  logic                  i_loop_done,
  input  logic [ADDR_WIDTH-1:0] i_pattern_num,
  input  logic [DATA_WIDTH-1:0] i_bank_l,
  input  logic [ADDR_WIDTH-1:0] i_bank_addr,
  input  logic                  i_bank_wr,
  input  logic                  i_pat_wr,
  input  logic [ADDR_WIDTH-1:0] i_pat_addr,
  input  logic [DATA_WIDTH-1:0] i_pat_data,
  input  logic                  i_clear,
  output logic                  o_busy,
  output logic                  o_check_done,
  output logic                  o_pass,
  output logic [CNT_WIDTH-1:0]  o_word_err_cnt,
  output logic [CNT_WIDTH-1:0]  o_bit_err_cnt,
  output logic [CNT_WIDTH-1:0]  o_loop_cnt,
  output logic                  o_overrun,
  output logic [ADDR_WIDTH-1:0] o_first_err_addr,
  output logic [DATA_WIDTH-1:0] o_first_err_data
);

  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int PCNT_WIDTH = pcnt_width(DATA_WIDTH);

  function automatic logic [CNT_WIDTH-1:0] sat_add(
    input logic [CNT_WIDTH-1:0] a,
    input logic [CNT_WIDTH-1:0] b
  );
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
  endfunction

  logic [1:0]            state;
  logic                  wsel;
  logic                  csel;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] pat_num [2];
  logic [DEPTH-1:0]      written [2];
  logic [DATA_WIDTH-1:0] rx_bank [2][DEPTH];
  logic [DATA_WIDTH-1:0] pat_bank [DEPTH];

  logic [DATA_WIDTH-1:0] diff_p1;
  logic                  miss_p1;
  logic [PCNT_WIDTH-1:0] diff_pcnt;

  logic                  loop_err;
  logic                  pass;
  logic                  overrun;
  logic [CNT_WIDTH-1:0]  word_err_cnt;
  logic [CNT_WIDTH-1:0]  bit_err_cnt;
  logic [CNT_WIDTH-1:0]  loop_cnt;

  logic                  done_accept;
  logic                  start_sel;
  logic                  err_now;
  logic                  last_word;
  logic [CNT_WIDTH-1:0]  bit_addend;

  always_comb begin
    done_accept = i_loop_done && (state == S_IDLE);
    // A start coinciding with an accepted loop end belongs to the next loop,
    // which is captured in the bank that becomes active after the toggle.
    start_sel   = done_accept ? ~wsel : wsel;
    err_now     = miss_p1 || (diff_p1 != '0);
    last_word   = (idx == pat_num[csel]);
    // An unwritten word counts as every bit wrong.
    bit_addend  = miss_p1 ? CNT_WIDTH'(DATA_WIDTH) : CNT_WIDTH'(diff_pcnt);
  end

  // Capture control: bank select, written flags, per-bank loop length.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      wsel       <= 1'b0;
      written[0] <= '0;
      written[1] <= '0;
      pat_num[0] <= '0;
      pat_num[1] <= '0;
    end else begin
      if (done_accept) begin
        wsel <= ~wsel;
      end
      if (i_loop_start) begin
        written[start_sel] <= '0;
        pat_num[start_sel] <= i_pattern_num;
      end
      // Uses the pre-toggle select, so a write in the loop-end cycle lands
      // in the bank about to be checked.
      if (i_bank_wr) begin
        written[wsel][i_bank_addr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_bank_wr) begin
      rx_bank[wsel][i_bank_addr] <= i_bank_l;
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pat_bank[i] <= '0;
      end
    end else if (i_pat_wr) begin
      pat_bank[i_pat_addr] <= i_pat_data;
    end
  end

  // Stage p1: word difference and missing-word flag, registered in S_COMPARE.
  always_ff @(posedge i_clk) begin
    if (state == S_COMPARE) begin
      diff_p1 <= rx_bank[csel][idx] ^ pat_bank[idx];
      miss_p1 <= ~written[csel][idx];
    end
  end

  loop_checker_popcount #(
    .DATA_WIDTH (DATA_WIDTH),
    .PCNT_WIDTH (PCNT_WIDTH)
  ) u_popcount (
    .data  (diff_p1),
    .count (diff_pcnt)
  );

  // Stage p2: sequencing and statistics accumulation.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state        <= S_IDLE;
      csel         <= 1'b0;
      idx          <= '0;
      loop_err     <= 1'b0;
      pass         <= 1'b0;
      overrun      <= 1'b0;
      word_err_cnt <= '0;
      bit_err_cnt  <= '0;
      loop_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_loop_done) begin
            csel     <= wsel;
            idx      <= '0;
            loop_err <= 1'b0;
            state    <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          state <= S_ACCUM;
        end
        S_ACCUM: begin
          if (err_now) begin
            loop_err     <= 1'b1;
            word_err_cnt <= sat_add(word_err_cnt, CNT_WIDTH'(1));
            bit_err_cnt  <= sat_add(bit_err_cnt, bit_addend);
          end
          if (last_word) begin
            // Result and loop count become visible together with check_done.
            pass     <= ~(loop_err || err_now);
            loop_cnt <= sat_add(loop_cnt, CNT_WIDTH'(1));
            state    <= S_DONE;
          end else begin
            idx   <= idx + ADDR_WIDTH'(1);
            state <= S_COMPARE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      if (i_loop_done && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end

      // Clear wins over same-cycle updates but leaves the sequencer running.
      if (i_clear) begin
        pass         <= 1'b0;
        overrun      <= 1'b0;
        word_err_cnt <= '0;
        bit_err_cnt  <= '0;
        loop_cnt     <= '0;
      end
    end
  end

`ifdef LOOP_RESULT_CHECKER_ERR_LOG_EN
  logic [DATA_WIDTH-1:0] rx_word_p1;
  logic                  first_err_vld;
  logic [ADDR_WIDTH-1:0] first_err_addr;
  logic [DATA_WIDTH-1:0] first_err_data;

  always_ff @(posedge i_clk) begin
    if (state == S_COMPARE) begin
      rx_word_p1 <= rx_bank[csel][idx];
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      first_err_vld  <= 1'b0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (i_clear) begin
      first_err_vld  <= 1'b0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if ((state == S_ACCUM) && err_now && !first_err_vld) begin
      first_err_vld  <= 1'b1;
      first_err_addr <= idx;
      first_err_data <= rx_word_p1;
    end
  end

  assign o_first_err_addr = first_err_addr;
  assign o_first_err_data = first_err_data;
`else
  assign o_first_err_addr = '0;
  assign o_first_err_data = '0;
`endif

  assign o_busy         = (state != S_IDLE);
  assign o_check_done   = (state == S_DONE);
  assign o_pass         = pass;
  assign o_overrun      = overrun;
  assign o_word_err_cnt = word_err_cnt;
  assign o_bit_err_cnt  = bit_err_cnt;
  assign o_loop_cnt     = loop_cnt;

endmodule

// File: tb/tb_loop_result_checker.sv
// ---------------------------------------------------------------------------
// tb_loop_result_checker
// Directed bench for loop_result_checker with a loop-level reference model:
// each accepted loop end is evaluated at once over the captured words, and
// the result is expected on the check_done cycle 2*(pattern_num+1)+1 cycles
// later.
// ---------------------------------------------------------------------------
module tb_loop_result_checker;

  localparam int DW    = 56;
  localparam int AW    = 3;
  localparam int CW    = 16;
  localparam int DEPTH = 8;

  logic          i_clk;
  logic          i_arst;
  logic          i_loop_start;
  logic          i_loop_done;
  logic [AW-1:0] i_pattern_num;
  logic [DW-1:0] i_bank_l;
  logic [AW-1:0] i_bank_addr;
  logic          i_bank_wr;
  logic          i_pat_wr;
  logic [AW-1:0] i_pat_addr;
  logic [DW-1:0] i_pat_data;
  logic          i_clear;
  logic          o_busy;
  logic          o_check_done;
  logic          o_pass;
  logic [CW-1:0] o_word_err_cnt;
  logic [CW-1:0] o_bit_err_cnt;
  logic [CW-1:0] o_loop_cnt;
  logic          o_overrun;
  logic [AW-1:0] o_first_err_addr;
  logic [DW-1:0] o_first_err_data;

  loop_result_checker dut (
    .i_clk            (i_clk),
    .i_arst           (i_arst),
    .i_loop_start     (i_loop_start),
    .i_loop_done      (i_loop_done),
    .i_pattern_num    (i_pattern_num),
    .i_bank_l         (i_bank_l),
    .i_bank_addr      (i_bank_addr),
    .i_bank_wr        (i_bank_wr),
    .i_pat_wr         (i_pat_wr),
    .i_pat_addr       (i_pat_addr),
    .i_pat_data       (i_pat_data),
    .i_clear          (i_clear),
    .o_busy           (o_busy),
    .o_check_done     (o_check_done),
    .o_pass           (o_pass),
    .o_word_err_cnt   (o_word_err_cnt),
    .o_bit_err_cnt    (o_bit_err_cnt),
    .o_loop_cnt       (o_loop_cnt),
    .o_overrun        (o_overrun),
    .o_first_err_addr (o_first_err_addr),
    .o_first_err_data (o_first_err_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_err = 0;
  bit run_chk = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pat_val(input int a);
    return 56'h00AA5500000000 + DW'(a) * 56'h0000000101;
  endfunction

  function automatic int sat(input int x);
    return (x > 65535) ? 65535 : x;
  endfunction

  // ---------------- reference model ----------------
  logic [DW-1:0] m_pat [DEPTH];
  logic [DW-1:0] m_rx [2][DEPTH];
  bit            m_wr [2][DEPTH];
  bit            m_known [2][DEPTH];
  int            m_pn [2];
  int            m_wsel, m_cd, m_words, m_bits, m_loops;
  bit            m_pass, m_ovr, m_acc;
  int            m_ss, m_nb;
  int            p_words, p_bits;
  bit            p_fe, p_fe_known;
  int            p_fe_addr;
  logic [DW-1:0] p_fe_data;
  bit            m_fe_vld, m_fe_known;
  int            m_fe_addr;
  logic [DW-1:0] m_fe_data;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) begin
        m_rx[b][a]    = '0;
        m_known[b][a] = 1'b0;
      end
  end

  always @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      for (int a = 0; a < DEPTH; a++) begin
        m_pat[a]   = '0;
        m_wr[0][a] = 1'b0;
        m_wr[1][a] = 1'b0;
      end
      m_pn[0] = 0; m_pn[1] = 0;
      m_wsel = 0; m_cd = 0;
      m_words = 0; m_bits = 0; m_loops = 0;
      m_pass = 1'b0; m_ovr = 1'b0;
      m_fe_vld = 1'b0; m_fe_addr = 0; m_fe_data = '0; m_fe_known = 1'b1;
    end else begin
      m_acc = i_loop_done && (m_cd == 0);
      if (i_loop_done && (m_cd != 0)) m_ovr = 1'b1;
      m_ss = m_acc ? 1 - m_wsel : m_wsel;
      if (i_loop_start) begin
        for (int a = 0; a < DEPTH; a++) m_wr[m_ss][a] = 1'b0;
        m_pn[m_ss] = int'(i_pattern_num);
      end
      if (i_bank_wr) begin
        m_rx[m_wsel][i_bank_addr]    = i_bank_l;
        m_wr[m_wsel][i_bank_addr]    = 1'b1;
        m_known[m_wsel][i_bank_addr] = 1'b1;
      end
      if (i_pat_wr) m_pat[i_pat_addr] = i_pat_data;
      if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 1) begin
          m_words += p_words;
          m_bits  += p_bits;
          m_loops++;
          m_pass = (p_words == 0);
          if (p_fe && !m_fe_vld) begin
            m_fe_vld = 1'b1; m_fe_addr = p_fe_addr;
            m_fe_data = p_fe_data; m_fe_known = p_fe_known;
          end
        end
      end
      if (m_acc) begin
        p_words = 0; p_bits = 0; p_fe = 1'b0;
        for (int a = 0; a <= m_pn[m_wsel]; a++) begin
          m_nb = m_wr[m_wsel][a] ? $countones(m_rx[m_wsel][a] ^ m_pat[a]) : DW;
          if (m_nb > 0) begin
            p_words++;
            p_bits += m_nb;
            if (!p_fe) begin
              p_fe = 1'b1; p_fe_addr = a;
              p_fe_data = m_rx[m_wsel][a]; p_fe_known = m_known[m_wsel][a];
            end
          end
        end
        m_cd   = 2 * (m_pn[m_wsel] + 1) + 1;
        m_wsel = 1 - m_wsel;
      end
      if (i_clear) begin
        m_words = 0; m_bits = 0; m_loops = 0;
        m_pass = 1'b0; m_ovr = 1'b0;
        m_fe_vld = 1'b0; m_fe_addr = 0; m_fe_data = '0; m_fe_known = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge i_clk) begin
    if (run_chk) begin
      chk("busy", o_busy, m_cd > 0);
      chk("check_done", o_check_done, m_cd == 1);
      chk("overrun", o_overrun, m_ovr);
      if (m_cd <= 1) begin
        chk("pass", o_pass, m_pass);
        chk("word_err_cnt", o_word_err_cnt, sat(m_words));
        chk("bit_err_cnt", o_bit_err_cnt, sat(m_bits));
        chk("loop_cnt", o_loop_cnt, sat(m_loops));
`ifdef LOOP_RESULT_CHECKER_ERR_LOG_EN
        chk("first_err_addr", o_first_err_addr, m_fe_vld ? m_fe_addr : 0);
        if (m_fe_known) chk("first_err_data", o_first_err_data, m_fe_vld ? m_fe_data : '0);
`else
        chk("first_err_addr", o_first_err_addr, 0);
        chk("first_err_data", o_first_err_data, 0);
`endif
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pat_write(input int a, input logic [DW-1:0] d);
    i_pat_wr = 1'b1; i_pat_addr = AW'(a); i_pat_data = d;
    cyc();
    i_pat_wr = 1'b0;
  endtask

  task automatic rx_write(input int a, input logic [DW-1:0] d);
    i_bank_wr = 1'b1; i_bank_addr = AW'(a); i_bank_l = d;
    cyc();
    i_bank_wr = 1'b0;
  endtask

  task automatic do_start(input int pn);
    i_loop_start = 1'b1; i_pattern_num = AW'(pn);
    cyc();
    i_loop_start = 1'b0;
  endtask

  task automatic do_done();
    i_loop_done = 1'b1;
    cyc();
    i_loop_done = 1'b0;
  endtask

  // Returns the number of negedges until check_done, -1 on timeout.
  task automatic wait_check(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge i_clk);
      if (o_check_done) begin
        lat = k;
        break;
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  int lat;
  int ndone;

  initial begin
    i_arst = 1'b0; i_loop_start = 1'b0; i_loop_done = 1'b0; i_pattern_num = '0;
    i_bank_l = '0; i_bank_addr = '0; i_bank_wr = 1'b0;
    i_pat_wr = 1'b0; i_pat_addr = '0; i_pat_data = '0; i_clear = 1'b0;
    #2 i_arst = 1'b1;
    run_chk = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_busy", o_busy, 0);
    chk("reset_loop_cnt", o_loop_cnt, 0);
    chk("reset_word_err", o_word_err_cnt, 0);
    i_arst = 1'b0;
    cyc();
    for (int a = 0; a < DEPTH; a++) pat_write(a, pat_val(a));

    // all words match
    do_start(3);
    for (int a = 0; a < 4; a++) rx_write(a, pat_val(a));
    do_done();
    wait_check(lat);
    chk("t1_latency", lat, 9);
    chk("t1_pass", o_pass, 1);
    chk("t1_bit_err", o_bit_err_cnt, 0);
    chk("t1_loop_cnt", o_loop_cnt, 1);

    // word 2 has four flipped bits
    do_start(3);
    for (int a = 0; a < 4; a++) rx_write(a, (a == 2) ? pat_val(a) ^ 56'hF : pat_val(a));
    do_done();
    wait_check(lat);
    chk("t2_latency", lat, 9);
    chk("t2_pass", o_pass, 0);
    chk("t2_word_err", o_word_err_cnt, 1);
    chk("t2_bit_err", o_bit_err_cnt, 4);
`ifdef LOOP_RESULT_CHECKER_ERR_LOG_EN
    chk("t2_first_err_addr", o_first_err_addr, 2);
    chk("t2_first_err_data", o_first_err_data, pat_val(2) ^ 56'hF);
`endif

    // address 1 never written
    do_start(2);
    rx_write(0, pat_val(0));
    rx_write(2, pat_val(2));
    do_done();
    wait_check(lat);
    chk("t3_latency", lat, 7);
    chk("t3_word_err", o_word_err_cnt, 2);
    chk("t3_bit_err", o_bit_err_cnt, 60);
    chk("t3_loop_cnt", o_loop_cnt, 3);

    // back-to-back loops, next loop captured during the check
    do_start(1);
    rx_write(0, pat_val(0));
    rx_write(1, pat_val(1));
    do_done();
    do_start(2);
    rx_write(0, pat_val(0));
    rx_write(1, pat_val(1) ^ 56'hFF);
    wait_check(lat);
    chk("t4a_seen", lat > 0, 1);
    chk("t4a_pass", o_pass, 1);
    chk("t4a_loop_cnt", o_loop_cnt, 4);
    rx_write(2, pat_val(2));
    do_done();
    wait_check(lat);
    chk("t4b_latency", lat, 7);
    chk("t4b_bit_err", o_bit_err_cnt, 68);
    chk("t4b_loop_cnt", o_loop_cnt, 5);

    // loop end, last write and next start in the same cycle
    do_start(0);
    i_loop_done = 1'b1; i_bank_wr = 1'b1; i_bank_addr = '0; i_bank_l = pat_val(0);
    i_loop_start = 1'b1; i_pattern_num = AW'(1);
    cyc();
    i_loop_done = 1'b0; i_bank_wr = 1'b0; i_loop_start = 1'b0;
    rx_write(0, pat_val(0));
    wait_check(lat);
    chk("t5a_seen", lat > 0, 1);
    chk("t5a_pass", o_pass, 1);
    rx_write(1, pat_val(1));
    do_done();
    wait_check(lat);
    chk("t5b_latency", lat, 5);
    chk("t5b_pass", o_pass, 1);
    chk("t5b_loop_cnt", o_loop_cnt, 7);

    // loop end while checking -> overrun, then clear
    do_start(3);
    for (int a = 0; a < 4; a++) rx_write(a, pat_val(a));
    do_done();
    do_done();
    wait_check(lat);
    chk("t6_seen", lat > 0, 1);
    chk("t6_overrun", o_overrun, 1);
    chk("t6_loop_cnt", o_loop_cnt, 8);
    repeat (4) cyc();
    i_clear = 1'b1;
    cyc();
    i_clear = 1'b0;
    chk("t6_clr_word", o_word_err_cnt, 0);
    chk("t6_clr_bit", o_bit_err_cnt, 0);
    chk("t6_clr_loop", o_loop_cnt, 0);
    chk("t6_clr_overrun", o_overrun, 0);

    // full depth, error in last word
    do_start(7);
    for (int a = 0; a < 8; a++) rx_write(a, (a == 7) ? pat_val(a) ^ (56'h1 << 55) : pat_val(a));
    do_done();
    wait_check(lat);
    chk("t7_latency", lat, 17);
    chk("t7_bit_err", o_bit_err_cnt, 1);
    chk("t7_loop_cnt", o_loop_cnt, 1);
`ifdef LOOP_RESULT_CHECKER_ERR_LOG_EN
    chk("t7_first_err_addr", o_first_err_addr, 7);
`endif

    // saturate bit error counter with all-miss loops
    for (int n = 0; n < 147; n++) begin
      do_start(7);
      do_done();
      wait_check(lat);
    end
    chk("t8_bit_sat", o_bit_err_cnt, 16'hFFFF);
    chk("t8_word_err", o_word_err_cnt, 1 + 147 * 8);
    chk("t8_loop_cnt", o_loop_cnt, 148);
    chk("t8_pass", o_pass, 0);

    // reset during a check
    do_start(3);
    for (int a = 0; a < 4; a++) rx_write(a, pat_val(a));
    do_done();
    cyc();
    cyc();
    #2 i_arst = 1'b1;
    #1;
    chk("t9_busy", o_busy, 0);
    chk("t9_check_done", o_check_done, 0);
    chk("t9_bit_err", o_bit_err_cnt, 0);
    cyc();
    cyc();
    i_arst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (o_check_done) ndone++;
    end
    chk("t9_no_done", ndone, 0);
    cyc();
    // pattern bank is zero after reset
    do_start(0);
    rx_write(0, '0);
    do_done();
    wait_check(lat);
    chk("t10_latency", lat, 3);
    chk("t10_pass", o_pass, 1);
    chk("t10_loop_cnt", o_loop_cnt, 1);

    repeat (3) cyc();
    run_chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
